pool2_ctrl: RTL and testbench

- Sequencer for the 16-channel layer-2 max-pooling datapath.
- On a start pulse it scans the F4 feature buffer (IN_H x IN_W per channel, all 16 channels read in parallel as one 256-bit word) in 2x2 windows.
- For each window it generates F4 read addresses and the pool2_clr window-restart strobe, then issues F5 write enables and addresses aligned to the pooled result.
- Sits between the layer scheduler (start/done) and the pool2 datapath plus its F4/F5 buffers.

---
 rtl/pool2_ctrl.sv | 124 ++++++++++++
 tb/tb_pool2_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2_ctrl.sv
// Sequencer for the layer-2 2x2 max-pooling datapath: scans F4 in 2x2 windows,
// aligns pool2_clr with returning read data and writes each pooled word to F5.
module pool2_ctrl #(
    parameter int IN_W    = 8,
    parameter int IN_H    = 8,
    parameter int RD_LAT  = 1,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               f4_re,
    output logic [ADDR_W-1:0]  f4_raddr,
    output logic               pool2_clr,
    output logic               f5_we,
    output logic [OADDR_W-1:0] f5_waddr
);
    localparam int COLS = IN_W / 2;
    localparam int ROWS = IN_H / 2;
    localparam int NWIN = COLS * ROWS;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         elem, elem_nxt;
    logic [CW-1:0]      ocol, ocol_nxt;
    logic [RW-1:0]      orow, orow_nxt;
    logic [ADDR_W-1:0]  raddr_nxt;
    logic [OADDR_W-1:0] wr_cnt;
    logic [RD_LAT-1:0]  clr_pipe;
    logic [RD_LAT:0]    wr_pipe;
    logic               accept, last_rd, last_wr;

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE
    // (busy=0); busy covers the whole scan and done pulses once when the last
    // F5 word is written. Requests while busy are dropped, never queued.
    assign accept  = start && (state == IDLE || state == DONE);
    assign last_rd = (elem == 2'd3) && (int'(ocol) == COLS - 1) && (int'(orow) == ROWS - 1);
    assign last_wr = f5_we && (int'(f5_waddr) == NWIN - 1);

    assign f4_re     = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign pool2_clr = clr_pipe[RD_LAT-1];
    assign f5_we     = wr_pipe[RD_LAT];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_rd) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters describe the element currently on f4_raddr; this computes the next one.
    always_comb begin
        elem_nxt = elem + 2'd1;
        ocol_nxt = ocol;
        orow_nxt = orow;
        if (elem == 2'd3) begin
            if (int'(ocol) == COLS - 1) begin
                ocol_nxt = '0;
                orow_nxt = (int'(orow) == ROWS - 1) ? '0 : orow + RW'(1);
            end else begin
                ocol_nxt = ocol + CW'(1);
            end
        end
        raddr_nxt = ADDR_W'((2 * int'(orow_nxt) + int'(elem_nxt[1])) * IN_W
                            + 2 * int'(ocol_nxt) + int'(elem_nxt[0]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            elem     <= '0;
            ocol     <= '0;
            orow     <= '0;
            f4_raddr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                elem     <= '0;
                ocol     <= '0;
                orow     <= '0;
                f4_raddr <= '0;
            end else if (state == RUN && !last_rd) begin
                elem     <= elem_nxt;
                ocol     <= ocol_nxt;
                orow     <= orow_nxt;
                f4_raddr <= raddr_nxt;
            end
        end
    end

    // Window-start and window-end flags ride delay lines matched to the F4 read
    // latency; the end flag gets one extra stage for the pool register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_pipe <= '0;
            wr_pipe  <= '0;
            wr_cnt   <= '0;
            f5_waddr <= '0;
        end else begin
            clr_pipe[0] <= f4_re && (elem == 2'd0);
            for (int i = 1; i < RD_LAT; i++) clr_pipe[i] <= clr_pipe[i-1];
            wr_pipe[0] <= f4_re && (elem == 2'd3);
            for (int i = 1; i <= RD_LAT; i++) wr_pipe[i] <= wr_pipe[i-1];
            if (accept) begin
                wr_cnt <= '0;
            end else if (wr_pipe[RD_LAT-1]) begin
                f5_waddr <= wr_cnt;
                wr_cnt   <= wr_cnt + OADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pool2_ctrl.sv
// Bench for pool2_ctrl: three configurations checked cycle by cycle against a
// closed-form timing model, plus an F4/pool/F5 model on the default instance.
module tb_pool2_ctrl;
    localparam int CH = 16;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       re;
        logic [7:0] raddr;
        logic       clr;
        logic       we;
        logic [7:0] waddr;
    } obs_t;

    typedef struct {
        int which;
        bit pre;
        bit chain;
        int mode;
        int s1;
        int s2;
        int exp_wr;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c;
    logic busy_a, done_a, re_a, clr_a, we_a;
    logic busy_b, done_b, re_b, clr_b, we_b;
    logic busy_c, done_c, re_c, clr_c, we_c;
    logic [5:0] raddr_a, raddr_b;
    logic [3:0] waddr_a, waddr_b, raddr_c;
    logic [1:0] waddr_c;
    obs_t obs_a, obs_b, obs_c;

    int checks = 0;
    int errors = 0;

    pool2_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .f4_re(re_a), .f4_raddr(raddr_a), .pool2_clr(clr_a), .f5_we(we_a), .f5_waddr(waddr_a)
    );
    pool2_ctrl #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .f4_re(re_b), .f4_raddr(raddr_b), .pool2_clr(clr_b), .f5_we(we_b), .f5_waddr(waddr_b)
    );
    pool2_ctrl #(.IN_W(4), .IN_H(4), .ADDR_W(4), .OADDR_W(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .f4_re(re_c), .f4_raddr(raddr_c), .pool2_clr(clr_c), .f5_we(we_c), .f5_waddr(waddr_c)
    );

    assign obs_a = {busy_a, done_a, re_a, 8'(raddr_a), clr_a, we_a, 8'(waddr_a)};
    assign obs_b = {busy_b, done_b, re_b, 8'(raddr_b), clr_b, we_b, 8'(waddr_b)};
    assign obs_c = {busy_c, done_c, re_c, 8'(raddr_c), clr_c, we_c, 8'(waddr_c)};

    // F4 buffer (latency 1), pool unit and F5 buffer around the default instance
    logic [255:0] f4_mem [64];
    logic [255:0] f5_mem [16];
    logic [255:0] rdata, pool_q;

    always @(posedge clk) begin
        if (re_a) rdata <= f4_mem[raddr_a];
        for (int c = 0; c < CH; c++)
            pool_q[c*16 +: 16] <= (clr_a || rdata[c*16 +: 16] > pool_q[c*16 +: 16])
                                  ? rdata[c*16 +: 16] : pool_q[c*16 +: 16];
        if (we_a) f5_mem[waddr_a] <= pool_q;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rd_addr(int i, int w);
        int win  = i / 4;
        int e    = i % 4;
        int half = w / 2;
        return (2 * (win / half) + e / 2) * w + 2 * (win % half) + e % 2;
    endfunction

    // Expected outputs t cycles after the start was sampled (t=0).
    function automatic obs_t model(int t, int w, int h, int l);
        obs_t o;
        int n = w * h;
        o = '0;
        o.busy = (t >= 1 && t <= n + 1 + l);
        o.done = (t == n + 2 + l);
        o.re   = (t >= 1 && t <= n);
        if (t >= 1) o.raddr = 8'(rd_addr((t <= n) ? t - 1 : n - 1, w));
        if (t >= 1 + l && (t - 1 - l) % 4 == 0 && (t - 1 - l) / 4 < n / 4) o.clr = 1'b1;
        if (t >= 5 + l && (t - 5 - l) % 4 == 0 && (t - 5 - l) / 4 < n / 4) begin
            o.we    = 1'b1;
            o.waddr = 8'((t - 5 - l) / 4);
        end
        return o;
    endfunction

    task automatic get_cfg(input int which, output int w, output int h, output int l);
        w = (which == 2) ? 4 : 8;
        h = w;
        l = (which == 1) ? 3 : 1;
    endtask

    function automatic obs_t get_obs(int which);
        if (which == 0) return obs_a;
        if (which == 1) return obs_b;
        return obs_c;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v;
        else if (which == 1) start_b = v;
        else start_c = v;
    endtask

    task automatic fill(input int mode);
        for (int a = 0; a < 64; a++)
            for (int c = 0; c < CH; c++)
                case (mode)
                    0:       f4_mem[a][c*16 +: 16] = 16'(a * 16 + c);
                    1:       f4_mem[a][c*16 +: 16] = 16'((63 - a) * 16 + c);
                    default: f4_mem[a][c*16 +: 16] = 16'($urandom);
                endcase
        for (int k = 0; k < 16; k++) f5_mem[k] = '0;
    endtask

    task automatic check_f5(input int mode);
        logic [255:0] exp;
        logic [15:0]  v;
        for (int k = 0; k < 16; k++) begin
            exp = '0;
            for (int c = 0; c < CH; c++)
                for (int e = 0; e < 4; e++) begin
                    v = f4_mem[rd_addr(4 * k + e, 8)][c*16 +: 16];
                    if (e == 0 || v > exp[c*16 +: 16]) exp[c*16 +: 16] = v;
                end
            check($sformatf("f5[%0d] mode%0d", k, mode), f5_mem[k], exp);
        end
        if (mode == 0) begin
            for (int c = 0; c < CH; c++) exp[c*16 +: 16] = 16'(9 * 16 + c);
            check("f5[0] bottom-right", f5_mem[0], exp);
            for (int c = 0; c < CH; c++) exp[c*16 +: 16] = 16'(63 * 16 + c);
            check("f5[15] bottom-right", f5_mem[15], exp);
        end
    endtask

    // Caller sits just after a rising edge; that cycle is t=0.
    task automatic scan(input int which, input bit pre, input int s1, input int s2,
                        input bit chain, output int nwr, output int done_t);
        int w, h, l, last;
        obs_t a, e;
        get_cfg(which, w, h, l);
        last   = w * h + 2 + l;
        nwr    = 0;
        done_t = -1;
        if (!pre) set_start(which, 1'b1);
        for (int t = 1; t <= last; t++) begin
            @(posedge clk);
            #1;
            set_start(which, (t == s1 || t == s2 || (chain && t == last)));
            a = get_obs(which);
            e = model(t, w, h, l);
            if (a.we) nwr++;
            if (a.done) done_t = t;
            if (!e.we) begin
                a.waddr = '0;
                e.waddr = '0;
            end
            check($sformatf("dut%0d t=%0d {busy,done,re,raddr,clr,we,waddr}", which, t),
                  {235'b0, a}, {235'b0, e});
        end
    endtask

    vec_t tbl[4];
    int   nwr, done_t, w, h, l, stray;

    initial begin
        tbl[0] = '{which: 0, pre: 0, chain: 1, mode: 0, s1: 10, s2: 66, exp_wr: 16, exp_done: 67};
        tbl[1] = '{which: 0, pre: 1, chain: 0, mode: 1,
                   s1: int'($urandom_range(1, 66)), s2: int'($urandom_range(1, 66)),
                   exp_wr: 16, exp_done: 67};
        tbl[2] = '{which: 1, pre: 0, chain: 0, mode: 2,
                   s1: int'($urandom_range(1, 68)), s2: 68, exp_wr: 16, exp_done: 69};
        tbl[3] = '{which: 2, pre: 0, chain: 0, mode: 2,
                   s1: int'($urandom_range(1, 18)), s2: 0, exp_wr: 4, exp_done: 19};

        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs a", {235'b0, obs_a}, 256'b0);
        check("reset outputs b", {235'b0, obs_b}, 256'b0);
        check("reset outputs c", {235'b0, obs_c}, 256'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            if (tbl[i].which == 0) fill(tbl[i].mode);
            scan(tbl[i].which, tbl[i].pre, tbl[i].s1, tbl[i].s2, tbl[i].chain, nwr, done_t);
            check($sformatf("row%0d write count", i), 256'(nwr), 256'(tbl[i].exp_wr));
            check($sformatf("row%0d done cycle", i), 256'(done_t), 256'(tbl[i].exp_done));
            if (tbl[i].which == 0) check_f5(tbl[i].mode);
            if (!tbl[i].chain) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of a layer, then a fresh layer
        fill(2);
        start_a = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("async reset outputs", {235'b0, obs_a}, 256'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stray = 0;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk);
            #1;
            if (we_a || done_a || busy_a || re_a) stray++;
        end
        check("activity after reset", 256'(stray), 256'b0);
        fill(2);
        scan(0, 1'b0, 0, 0, 1'b0, nwr, done_t);
        check("post-reset write count", 256'(nwr), 256'(16));
        check("post-reset done cycle", 256'(done_t), 256'(67));
        check_f5(2);

        get_cfg(0, w, h, l);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
